axil_bist_master: RTL and testbench

AXIL_BIST_MASTER -- requirements
Module: axil_bist_master

---
 rtl/axil_bist_if.sv | 33 +++
 rtl/axil_bist_master.sv | 184 ++++++++++++++++++
 tb/tb_axil_bist_master.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axil_bist_if.sv
// AXI4-Lite channel bundle between the BIST master and the register slave under test.
interface axil_bist_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   awaddr;
    logic                awvalid;
    logic                awready;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wvalid;
    logic                wready;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;
    logic [ADDR_W-1:0]   araddr;
    logic                arvalid;
    logic                arready;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rvalid;
    logic                rready;

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axil_bist_master.sv
// AXI4-Lite self-test master: writes a data pattern to NUM_REGS registers, reads
// them back and counts data mismatches and non-OKAY responses.
//   state   | meaning
//   IDLE    | waiting for start
//   WR_REQ  | AW and W offered for register idx
//   WR_RESP | waiting for the write response
//   RD_REQ  | AR offered for register idx
//   RD_DATA | waiting for the read beat, compare against pattern
//   DONE    | one-cycle done pulse, pass valid
module axil_bist_master #(
    parameter int                             C_M_AXI_ADDR_WIDTH = 32,
    parameter int                             C_M_AXI_DATA_WIDTH = 32,
    parameter int                             NUM_REGS           = 4,
    parameter logic [C_M_AXI_ADDR_WIDTH-1:0]  BASE_ADDR          = '0,
    parameter int                             PATTERN            = 0,
    parameter logic [C_M_AXI_DATA_WIDTH-1:0]  START_VAL          = 1
) (
    input  logic        ACLK,
    input  logic        ARESET,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [15:0] err_count,
    axil_bist_if.master m_axi
);
    localparam int         AW   = C_M_AXI_ADDR_WIDTH;
    localparam int         DW   = C_M_AXI_DATA_WIDTH;
    localparam int         SHW  = $clog2(DW);
    localparam int         BSH  = $clog2(DW / 8);
    localparam logic [7:0] LAST = 8'(NUM_REGS - 1);

    typedef enum logic [2:0] {
        IDLE,
        WR_REQ,
        WR_RESP,
        RD_REQ,
        RD_DATA,
        DONE
    } state_t;

    state_t          state_q, state_d;
    logic [7:0]      idx_q, idx_d;
    logic            aw_done_q, aw_done_d;
    logic            w_done_q, w_done_d;
    logic [AW-1:0]   awaddr_q, awaddr_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic [AW-1:0]   araddr_q, araddr_d;
    logic [15:0]     err_q, err_d;
    logic            pass_q, pass_d;
    logic            err_hit;
    logic            aw_hs, w_hs;

    function automatic logic [AW-1:0] addr_of(input logic [7:0] idx);
        return BASE_ADDR + (AW'(idx) << BSH);
    endfunction

    // Walking one wraps every DW registers; incrementing pattern wraps at 2^DW.
    function automatic logic [DW-1:0] pat_of(input logic [7:0] idx);
        logic [DW-1:0] one;
        one = DW'(1);
        if (PATTERN == 1) return one << idx[SHW-1:0];
        return START_VAL + DW'(idx);
    endfunction

    assign aw_hs = m_axi.awvalid && m_axi.awready;
    assign w_hs  = m_axi.wvalid && m_axi.wready;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        awaddr_d  = awaddr_q;
        wdata_d   = wdata_q;
        araddr_d  = araddr_q;
        err_d     = err_q;
        pass_d    = pass_q;
        err_hit   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = WR_REQ;
                    idx_d     = '0;
                    err_d     = '0;
                    pass_d    = 1'b0;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    awaddr_d  = addr_of(8'd0);
                    wdata_d   = pat_of(8'd0);
                end
            end
            WR_REQ: begin
                if (aw_hs) aw_done_d = 1'b1;
                if (w_hs)  w_done_d  = 1'b1;
                if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
                    state_d   = WR_RESP;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                end
            end
            WR_RESP: begin
                if (m_axi.bvalid) begin
                    err_hit = (m_axi.bresp != 2'b00);
                    if (idx_q == LAST) begin
                        state_d  = RD_REQ;
                        idx_d    = '0;
                        araddr_d = addr_of(8'd0);
                    end else begin
                        state_d  = WR_REQ;
                        idx_d    = idx_q + 8'd1;
                        awaddr_d = addr_of(idx_q + 8'd1);
                        wdata_d  = pat_of(idx_q + 8'd1);
                    end
                end
            end
            RD_REQ: begin
                if (m_axi.arready) state_d = RD_DATA;
            end
            RD_DATA: begin
                if (m_axi.rvalid) begin
                    err_hit = (m_axi.rdata != pat_of(idx_q)) || (m_axi.rresp != 2'b00);
                    if (idx_q == LAST) begin
                        state_d = DONE;
                    end else begin
                        state_d  = RD_REQ;
                        idx_d    = idx_q + 8'd1;
                        araddr_d = addr_of(idx_q + 8'd1);
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (err_hit && (err_q != 16'hFFFF)) err_d = err_q + 16'd1;
        // pass must see the count including the final read beat
        if ((state_q == RD_DATA) && (state_d == DONE)) pass_d = (err_d == 16'd0);
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            araddr_q  <= '0;
            err_q     <= '0;
            pass_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            awaddr_q  <= awaddr_d;
            wdata_q   <= wdata_d;
            araddr_q  <= araddr_d;
            err_q     <= err_d;
            pass_q    <= pass_d;
        end
    end

    assign m_axi.awaddr  = awaddr_q;
    assign m_axi.awvalid = (state_q == WR_REQ) && !aw_done_q;
    assign m_axi.wdata   = wdata_q;
    assign m_axi.wstrb   = '1;
    assign m_axi.wvalid  = (state_q == WR_REQ) && !w_done_q;
    assign m_axi.bready  = (state_q == WR_RESP);
    assign m_axi.araddr  = araddr_q;
    assign m_axi.arvalid = (state_q == RD_REQ);
    assign m_axi.rready  = (state_q == RD_DATA);

    assign busy      = (state_q != IDLE) && (state_q != DONE);
    assign done      = (state_q == DONE);
    assign pass      = pass_q;
    assign err_count = err_q;
endmodule

// File: tb/tb_axil_bist_master.sv
// Directed bench: default 4-register master against a configurable memory slave,
// plus a 34-register walking-one master against an always-ready memory slave.
module tb_axil_bist_master;
    localparam logic [31:0] NONE = 32'hDEAD_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_a, start_b;
    logic        busy_a, done_a, pass_a, busy_b, done_b, pass_b;
    logic [15:0] err_a, err_b;
    int          n_tests = 0;
    int          n_fail  = 0;

    always #5 clk = ~clk;

    axil_bist_if #(.ADDR_W(32), .DATA_W(32)) ifa ();
    axil_bist_if #(.ADDR_W(32), .DATA_W(32)) ifb ();

    axil_bist_master dut_a (
        .ACLK(clk), .ARESET(rst), .start(start_a), .busy(busy_a), .done(done_a),
        .pass(pass_a), .err_count(err_a), .m_axi(ifa)
    );

    axil_bist_master #(.NUM_REGS(34), .PATTERN(1)) dut_b (
        .ACLK(clk), .ARESET(rst), .start(start_b), .busy(busy_b), .done(done_b),
        .pass(pass_b), .err_count(err_b), .m_axi(ifb)
    );

    // Slave A: memory with AWREADY delay, forced read corruption and forced SLVERR
    int          aw_delay;
    logic [31:0] bad_rd, bad_b;
    int          aw_cnt;
    logic        aw_have, w_have;
    logic [31:0] aw_q, wd_q;
    logic        bvalid_a, rvalid_a;
    logic [1:0]  bresp_a;
    logic [31:0] rdata_a;
    logic [31:0] mem_a [16];
    int          n_aw, n_w, n_wr, n_ar;
    logic [31:0] wlog_a [8];
    logic [31:0] wlog_d [8];
    logic [31:0] arlog  [8];
    logic        aw_hs, w_hs, wr_both;
    logic [31:0] cur_a, cur_w;

    assign ifa.awready = (aw_cnt >= aw_delay);
    assign ifa.wready  = 1'b1;
    assign ifa.bvalid  = bvalid_a;
    assign ifa.bresp   = bresp_a;
    assign ifa.arready = 1'b1;
    assign ifa.rvalid  = rvalid_a;
    assign ifa.rdata   = rdata_a;
    assign ifa.rresp   = 2'b00;

    assign aw_hs   = ifa.awvalid && ifa.awready;
    assign w_hs    = ifa.wvalid && ifa.wready;
    assign cur_a   = aw_hs ? ifa.awaddr : aw_q;
    assign cur_w   = w_hs ? ifa.wdata : wd_q;
    assign wr_both = (aw_have || aw_hs) && (w_have || w_hs);

    always @(posedge clk) begin
        if (rst) begin
            aw_have <= 1'b0; w_have <= 1'b0; bvalid_a <= 1'b0; rvalid_a <= 1'b0;
            bresp_a <= 2'b00; rdata_a <= '0; aw_q <= '0; wd_q <= '0;
            n_aw <= 0; n_w <= 0; n_wr <= 0; n_ar <= 0; aw_cnt <= 0;
            for (int k = 0; k < 16; k++) mem_a[k] <= '0;
        end else begin
            if (aw_hs) begin
                aw_q <= ifa.awaddr; aw_have <= 1'b1; n_aw <= n_aw + 1; aw_cnt <= 0;
            end else if (ifa.awvalid) begin
                aw_cnt <= aw_cnt + 1;
            end
            if (w_hs) begin
                wd_q <= ifa.wdata; w_have <= 1'b1; n_w <= n_w + 1;
            end
            if (wr_both) begin
                mem_a[cur_a[5:2]] <= cur_w;
                wlog_a[n_wr[2:0]] <= cur_a;
                wlog_d[n_wr[2:0]] <= cur_w;
                n_wr     <= n_wr + 1;
                aw_have  <= 1'b0;
                w_have   <= 1'b0;
                bvalid_a <= 1'b1;
                bresp_a  <= (cur_a == bad_b) ? 2'b10 : 2'b00;
            end else if (bvalid_a && ifa.bready) begin
                bvalid_a <= 1'b0;
            end
            if (ifa.arvalid && ifa.arready) begin
                rvalid_a <= 1'b1;
                rdata_a  <= (ifa.araddr == bad_rd) ? 32'h0 : mem_a[ifa.araddr[5:2]];
                arlog[n_ar[2:0]] <= ifa.araddr;
                n_ar     <= n_ar + 1;
            end else if (rvalid_a && ifa.rready) begin
                rvalid_a <= 1'b0;
            end
        end
    end

    // Slave B: always-ready memory, AW and W always arrive together
    logic        bvalid_b, rvalid_b;
    logic [31:0] rdata_b;
    logic [31:0] mem_b [64];

    assign ifb.awready = 1'b1;
    assign ifb.wready  = 1'b1;
    assign ifb.bvalid  = bvalid_b;
    assign ifb.bresp   = 2'b00;
    assign ifb.arready = 1'b1;
    assign ifb.rvalid  = rvalid_b;
    assign ifb.rdata   = rdata_b;
    assign ifb.rresp   = 2'b00;

    always @(posedge clk) begin
        if (rst) begin
            bvalid_b <= 1'b0; rvalid_b <= 1'b0; rdata_b <= '0;
            for (int k = 0; k < 64; k++) mem_b[k] <= '0;
        end else begin
            if (ifb.awvalid && ifb.wvalid) begin
                mem_b[ifb.awaddr[7:2]] <= ifb.wdata;
                bvalid_b <= 1'b1;
            end else if (bvalid_b && ifb.bready) begin
                bvalid_b <= 1'b0;
            end
            if (ifb.arvalid) begin
                rvalid_b <= 1'b1;
                rdata_b  <= mem_b[ifb.araddr[7:2]];
            end else if (rvalid_b && ifb.rready) begin
                rvalid_b <= 1'b0;
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_done(output bit seen);
        seen = 1'b0;
        for (int c = 0; c < 1000; c++) begin
            @(negedge clk);
            if (done_a) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    // Pulse start for one cycle, count busy cycles until done, then watch for repeats.
    task automatic do_run(output int busy_cyc, output int done_cyc, output bit seen);
        start_a = 1'b1;
        @(negedge clk);
        start_a  = 1'b0;
        busy_cyc = 0;
        done_cyc = 0;
        seen     = 1'b0;
        for (int c = 0; c < 400; c++) begin
            if (busy_a) busy_cyc++;
            if (done_a) begin
                done_cyc++;
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        repeat (6) begin
            @(negedge clk);
            if (done_a) done_cyc++;
        end
    endtask

    typedef struct {
        int          aw_delay;
        logic [31:0] bad_rd;
        logic [31:0] bad_b;
        logic [15:0] exp_err;
        logic        exp_pass;
        int          exp_busy;
    } vec_t;

    vec_t vecs [5];

    initial begin
        int bc, dc;
        bit seen;

        vecs[0] = '{0, NONE,     NONE,     16'd0, 1'b1, 16};
        vecs[1] = '{0, 32'h8,    NONE,     16'd1, 1'b0, 16};
        vecs[2] = '{3, NONE,     NONE,     16'd0, 1'b1, 28};
        vecs[3] = '{0, NONE,     32'h4,    16'd1, 1'b0, 16};
        vecs[4] = '{2, 32'h4,    32'h4,    16'd2, 1'b0, 24};

        rst = 1'b1; start_a = 1'b0; start_b = 1'b0;
        aw_delay = 0; bad_rd = NONE; bad_b = NONE;
        do_reset();

        chk("rst_ctrl_a", {busy_a, done_a, pass_a}, 0);
        chk("rst_err_a", err_a, 0);
        chk("rst_valid_ready", {ifa.awvalid, ifa.wvalid, ifa.bready, ifa.arvalid, ifa.rready}, 0);
        chk("rst_addr", {ifa.awaddr, ifa.araddr}, 0);
        chk("rst_wdata", ifa.wdata, 0);
        chk("wstrb", ifa.wstrb, 4'hF);
        chk("rst_dut_b", {busy_b, done_b, pass_b, err_b}, 0);

        for (int v = 0; v < 5; v++) begin
            do_reset();
            aw_delay = vecs[v].aw_delay;
            bad_rd   = vecs[v].bad_rd;
            bad_b    = vecs[v].bad_b;
            do_run(bc, dc, seen);
            chk($sformatf("v%0d_done_seen", v), seen, 1);
            chk($sformatf("v%0d_done_pulses", v), dc, 1);
            chk($sformatf("v%0d_busy_cycles", v), bc, vecs[v].exp_busy);
            chk($sformatf("v%0d_err_count", v), err_a, vecs[v].exp_err);
            chk($sformatf("v%0d_pass", v), pass_a, vecs[v].exp_pass);
            chk($sformatf("v%0d_aw_xfers", v), n_aw, 4);
            chk($sformatf("v%0d_w_xfers", v), n_w, 4);
            chk($sformatf("v%0d_ar_xfers", v), n_ar, 4);
            for (int i = 0; i < 4; i++) begin
                chk($sformatf("v%0d_wr_addr%0d", v, i), wlog_a[i], 32'(i * 4));
                chk($sformatf("v%0d_wr_data%0d", v, i), wlog_d[i], 32'(i + 1));
                chk($sformatf("v%0d_rd_addr%0d", v, i), arlog[i], 32'(i * 4));
            end
        end

        // Reset while the read of register 2 is outstanding, then a clean run
        aw_delay = 0; bad_rd = NONE; bad_b = NONE;
        do_reset();
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 200; c++) begin
            if (ifa.rready && (ifa.araddr == 32'h8)) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("midrst_reached_rd2", seen, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_valid_ready", {ifa.awvalid, ifa.wvalid, ifa.bready, ifa.arvalid, ifa.rready}, 0);
        chk("midrst_busy", {busy_a, done_a, pass_a}, 0);
        chk("midrst_err", err_a, 0);
        @(negedge clk);
        do_run(bc, dc, seen);
        chk("midrst_rerun_done", seen, 1);
        chk("midrst_rerun_pass", pass_a, 1);
        chk("midrst_rerun_err", err_a, 0);
        chk("midrst_rerun_ar", n_ar, 4);

        // start held through DONE: IDLE for one cycle, then a fresh run clears err/pass
        do_reset();
        bad_rd  = 32'h8;
        start_a = 1'b1;
        wait_done(seen);
        chk("hold_first_done", seen, 1);
        chk("hold_first_err", err_a, 1);
        chk("hold_first_pass", pass_a, 0);
        bad_rd = NONE;
        @(negedge clk);
        chk("hold_idle_busy", {busy_a, done_a}, 0);
        @(negedge clk);
        chk("hold_restart_busy", busy_a, 1);
        chk("hold_restart_err_clr", err_a, 0);
        chk("hold_restart_pass_clr", pass_a, 0);
        start_a = 1'b0;
        wait_done(seen);
        chk("hold_second_done", seen, 1);
        chk("hold_second_pass", pass_a, 1);
        chk("hold_second_err", err_a, 0);

        // Walking one over 34 registers wraps after bit 31
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 1000; c++) begin
            if (done_b) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("walk_done", seen, 1);
        chk("walk_pass", pass_b, 1);
        chk("walk_err", err_b, 0);
        chk("walk_reg0", mem_b[0], 32'h0000_0001);
        chk("walk_reg5", mem_b[5], 32'h0000_0020);
        chk("walk_reg31", mem_b[31], 32'h8000_0000);
        chk("walk_reg32", mem_b[32], 32'h0000_0001);
        chk("walk_reg33", mem_b[33], 32'h0000_0002);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, got no end of test, expected completion");
        $fatal(1, "watchdog");
    end
endmodule
